// File: rtl/data_cache_controller_if.sv
// Simple request/response word bus used on both sides of the data cache.
// The requester drives address, data and enables; the responder returns read data and ready.
interface data_cache_controller_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rd_en;
    logic              wr_en;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (
        output addr, wdata, rd_en, wr_en,
        input  rdata, ready
    );

    modport slave (
        input  addr, wdata, rd_en, wr_en,
        output rdata, ready
    );
endinterface

// File: rtl/data_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache with one word per line.
// Load hits complete with zero stall; misses and every store go out to data memory.
module data_cache_controller #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 6
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    data_cache_controller_if.slave  cpu_if,
    data_cache_controller_if.master mem_if,
    output logic [15:0]             hit_count_o,
    output logic [15:0]             miss_count_o
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    typedef enum logic [1:0] {
        IDLE,
        READ_MEM,
        WRITE_MEM
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   req_addr_q;
    logic [DATA_W-1:0]   req_wdata_q;
    logic                mem_rd_q;
    logic                mem_wr_q;
    logic [15:0]         hit_count_q;
    logic [15:0]         miss_count_q;
    logic [15:0]         hit_count_d;
    logic [15:0]         miss_count_d;

    logic                valid_q [LINES];
    logic [TAG_W-1:0]    tag_q   [LINES];
    logic [DATA_W-1:0]   data_q  [LINES];

    logic [INDEX_W-1:0]  cpu_index;
    logic [TAG_W-1:0]    cpu_tag;
    logic [INDEX_W-1:0]  req_index;
    logic [TAG_W-1:0]    req_tag;
    logic                cpu_hit;
    logic                req_hit;
    logic                fill;
    logic                write_update;
    logic                cpu_ready;
    logic [DATA_W-1:0]   cpu_rdata;
    logic                unused_addr_bits;

    assign cpu_index = cpu_if.addr[INDEX_W+1:2];
    assign cpu_tag   = cpu_if.addr[ADDR_W-1:INDEX_W+2];
    assign req_index = req_addr_q[INDEX_W+1:2];
    assign req_tag   = req_addr_q[ADDR_W-1:INDEX_W+2];

    assign cpu_hit = valid_q[cpu_index] && (tag_q[cpu_index] == cpu_tag);
    assign req_hit = valid_q[req_index] && (tag_q[req_index] == req_tag);

    // Cache arrays never change on a reset edge, so an aborted fill leaves no trace.
    assign fill         = (state_q == READ_MEM)  && mem_if.ready && !rst_i;
    assign write_update = (state_q == WRITE_MEM) && mem_if.ready && req_hit && !rst_i;

    assign hit_count_d  = (hit_count_q  == 16'hFFFF) ? hit_count_q  : hit_count_q  + 16'd1;
    assign miss_count_d = (miss_count_q == 16'hFFFF) ? miss_count_q : miss_count_q + 16'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cpu_if.wr_en) begin
                        req_addr_q  <= cpu_if.addr;
                        req_wdata_q <= cpu_if.wdata;
                        mem_wr_q    <= 1'b1;
                        state_q     <= WRITE_MEM;
                    end else if (cpu_if.rd_en) begin
                        if (cpu_hit) begin
                            hit_count_q <= hit_count_d;
                        end else begin
                            req_addr_q   <= cpu_if.addr;
                            miss_count_q <= miss_count_d;
                            mem_rd_q     <= 1'b1;
                            state_q      <= READ_MEM;
                        end
                    end
                end
                READ_MEM: begin
                    if (mem_if.ready) begin
                        mem_rd_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                WRITE_MEM: begin
                    if (mem_if.ready) begin
                        mem_wr_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    mem_rd_q <= 1'b0;
                    mem_wr_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < LINES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (fill) begin
            valid_q[req_index] <= 1'b1;
        end
    end

    // Tags and data are left unreset; the valid bits alone qualify them.
    always_ff @(posedge clk_i) begin
        if (fill) begin
            tag_q[req_index]  <= req_tag;
            data_q[req_index] <= mem_if.rdata;
        end else if (write_update) begin
            data_q[req_index] <= req_wdata_q;
        end
    end

    always_comb begin
        cpu_ready = 1'b1;
        cpu_rdata = '0;
        unique case (state_q)
            IDLE: begin
                if (cpu_if.wr_en) begin
                    cpu_ready = 1'b0;
                end else if (cpu_if.rd_en) begin
                    if (cpu_hit) begin
                        cpu_rdata = data_q[cpu_index];
                    end else begin
                        cpu_ready = 1'b0;
                    end
                end
            end
            READ_MEM: begin
                cpu_ready = mem_if.ready;
                if (mem_if.ready) begin
                    cpu_rdata = mem_if.rdata;
                end
            end
            WRITE_MEM: begin
                cpu_ready = mem_if.ready;
            end
            default: begin
                cpu_ready = 1'b1;
            end
        endcase
    end

    assign cpu_if.ready  = cpu_ready;
    assign cpu_if.rdata  = cpu_rdata;
    assign mem_if.addr   = req_addr_q;
    assign mem_if.wdata  = req_wdata_q;
    assign mem_if.rd_en  = mem_rd_q;
    assign mem_if.wr_en  = mem_wr_q;
    assign hit_count_o   = hit_count_q;
    assign miss_count_o  = miss_count_q;

    assign unused_addr_bits = ^{cpu_if.addr[1:0], req_addr_q[1:0]};

endmodule

// File: doc/data_cache_controller.md
# data_cache_controller

Direct-mapped, write-through, no-write-allocate data cache between the MEM stage and the data memory. It services MEM-stage loads from a 64-entry word cache with zero stall on hit, and forwards every store to memory. It stalls the pipeline through `cpu_ready` while a memory transaction is outstanding. Its downstream port drives the data memory's address/WriteData/MemRead/MemWrite inputs and consumes its ReadData/ready outputs.

## Interface
- `ADDR_W`, 32, byte address width (matches `ADDRESS_LEN`)
- `DATA_W`, 32, word width (matches `INSTRUCTION_LEN`)
- `INDEX_W`, 6, index bits; lines = 2^INDEX_W, one word per line
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `cpu_addr`  in  ADDR_W  byte address from MEM stage (bits [1:0] ignored)
- `cpu_wdata`  in  DATA_W  store data
- `cpu_rd_en`  in  1  load request
- `cpu_wr_en`  in  1  store request
- `cpu_rdata`  out  DATA_W  load data, valid when `cpu_ready`=1 and a load is presented
- `cpu_ready`  out  1  0 = freeze pipeline; 1 = request completes this cycle
- `mem_addr`  out  ADDR_W  address to data memory (passed through unmodified; memory applies its own base offset)
- `mem_wdata`  out  DATA_W  store data to memory
- `mem_rd_en`  out  1  memory read enable
- `mem_wr_en`  out  1  memory write enable
- `mem_rdata`  in  DATA_W  memory read data
- `mem_ready`  in  1  memory completes the current access this cycle
- `hit_count`  out  16  saturating load-hit counter
- `miss_count`  out  16  saturating load-miss counter

## Operation
- Address split: index = `cpu_addr[INDEX_W+1:2]`, tag = `cpu_addr[ADDR_W-1:INDEX_W+2]`. Per line: valid bit, tag, data word.
- States: IDLE, READ_MEM, WRITE_MEM.
- IDLE, no request: `cpu_ready`=1, `cpu_rdata`=0, mem enables 0.
- IDLE, `cpu_wr_en`=1 (takes priority if `cpu_rd_en` is also 1): latch addr/wdata into the request registers, `cpu_ready`=0, go to WRITE_MEM.
- IDLE, `cpu_rd_en`=1, hit (valid and tag match): `cpu_rdata`=line data combinationally, `cpu_ready`=1, `hit_count`++; stay in IDLE.
- IDLE, `cpu_rd_en`=1, miss: latch addr, `cpu_ready`=0, `miss_count`++, go to READ_MEM.
- READ_MEM: `mem_rd_en`=1, `mem_addr`=latched addr. On `mem_ready`=1: fill line (valid=1, tag, `mem_rdata`), `cpu_rdata`=`mem_rdata`, `cpu_ready`=1, go to IDLE. Otherwise hold.
- WRITE_MEM: `mem_wr_en`=1, `mem_addr`/`mem_wdata` come from the latched registers. On `mem_ready`=1: if the latched address hits, update the line data; on a miss, leave the cache unchanged (no allocate). `cpu_ready`=1, go to IDLE.
- `mem_rd_en`/`mem_wr_en` are Moore outputs decoded from state; never both 1.
- The request registers hold stable for the whole transaction, independent of `cpu_*` changes.
- Counters saturate at 16'hFFFF. Stores are not counted.

## Timing
- Reset: state=IDLE, all valid bits=0, request registers=0, `mem_addr`=0, `mem_wdata`=0, `mem_rd_en`=0, `mem_wr_en`=0, `hit_count`=0, `miss_count`=0. `cpu_ready`=1 and `cpu_rdata`=0 once no request is presented. Line data/tags are not reset.
- Load hit: 0 stall cycles.
- Load miss, with `mem_ready` high: request cycle T (stall), data returned with `cpu_ready`=1 at T+1. Each low cycle of `mem_ready` adds one cycle.
- Store: T stall, completion at T+1 minimum. Exactly one cycle of `mem_wr_en` per store when `mem_ready`=1.
- `rst` during READ_MEM/WRITE_MEM: the transaction is aborted and enables are 0 in the next cycle. No line fill occurs on the reset edge, even if `mem_ready`=1.
- Index wrap: addresses 256 B apart share a line and evict each other.

## Test plan
- Reset, memory word @1024 = 0xA5A5_0001, load 1024 → `cpu_ready`=0 at T; `mem_rd_en`=1, `mem_addr`=1024 at T+1; `cpu_rdata`=0xA5A5_0001, `cpu_ready`=1 at T+1; `miss_count`=1.
- Reload 1024 → `cpu_ready`=1 same cycle, data 0xA5A5_0001, `mem_rd_en`=0, `hit_count`=1.
- Store 0x1234_5678 to 1024 (cached) → one `mem_wr_en` pulse with `mem_wdata`=0x1234_5678; reload 1024 hits and returns 0x1234_5678. Store 0xDEAD_BEEF to 1028 (uncached), then load 1028 → miss, returns 0xDEAD_BEEF.
- Alternate loads 1024, 1280, 1024 → three misses (`miss_count`+3), `mem_addr` follows each address.
- Hold `mem_ready`=0 for 3 cycles during a load miss → `cpu_ready`=0 and `mem_rd_en`=1 with `mem_addr` stable for 4 cycles, including while `cpu_addr` toggles; completes on the 4th.
- Assert `rst` during READ_MEM → next cycle IDLE, enables 0, counters 0; load of a previously cached 1024 misses.
